// File: rtl/sipo_drain_ctrl.sv
// AXI4-Lite read master that polls the SIPO capture FIFO STATUS register, reads DATA
// when words are pending and forwards each word on a valid/ready stream.
module sipo_drain_ctrl #(
  parameter int unsigned            ADDR_BITS = 32,
  parameter int unsigned            DATA_BITS = 32,
  parameter logic [ADDR_BITS-1:0]   BASE_ADDR = '0,
  parameter int unsigned            CNT_BITS  = 16,
  parameter int unsigned            POLL_GAP  = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_BITS-1:0]  cfg_words,
  output logic                 m_ar_valid,
  input  logic                 m_ar_ready,
  output logic [ADDR_BITS-1:0] m_ar_addr,
  output logic [2:0]           m_ar_prot,
  input  logic                 m_r_valid,
  output logic                 m_r_ready,
  input  logic [DATA_BITS-1:0] m_r_data,
  input  logic [1:0]           m_r_resp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ovf,
  output logic [CNT_BITS-1:0]  word_cnt
);

  typedef enum logic [3:0] {
    IDLE, POLL_AR, POLL_R, GAP, DATA_AR, DATA_R, PUSH, DONE, ERR
  } state_t;

  localparam int unsigned GAP_BITS = $clog2(POLL_GAP + 1);

  state_t              state, nxt;
  logic [GAP_BITS-1:0] gap_cnt;
  logic [CNT_BITS-1:0] cnt_inc;
  logic                ar_hs, r_hs, out_hs, resp_ok, gap_end, last_word;

  assign m_ar_prot = '0;
  assign ar_hs     = m_ar_valid && m_ar_ready;
  assign r_hs      = m_r_valid && m_r_ready;
  assign out_hs    = out_valid && out_ready;
  assign resp_ok   = (m_r_resp == 2'b00);
  assign cnt_inc   = word_cnt + CNT_BITS'(1);
  assign gap_end   = (gap_cnt == GAP_BITS'(POLL_GAP - 1));
  assign last_word = (cfg_words != '0) && (cnt_inc == cfg_words);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = POLL_AR;
      POLL_AR: if (ar_hs) nxt = POLL_R;
      POLL_R:
        if (r_hs) begin
          if (!resp_ok)       nxt = ERR;
          else if (m_r_data[0]) nxt = DATA_AR;
          else if (stop)      nxt = DONE;
          else                nxt = GAP;
        end
      GAP:
        if (stop)         nxt = DONE;
        else if (gap_end) nxt = POLL_AR;
      DATA_AR: if (ar_hs) nxt = DATA_R;
      DATA_R:
        if (r_hs) nxt = resp_ok ? PUSH : ERR;
      PUSH:
        if (out_hs) nxt = (last_word || stop) ? DONE : POLL_AR;
      DONE:    nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      m_ar_valid <= 1'b0;
      m_ar_addr  <= '0;
      m_r_ready  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ovf        <= 1'b0;
      word_cnt   <= '0;
    end else begin
      state      <= nxt;
      m_ar_valid <= (nxt == POLL_AR) || (nxt == DATA_AR);
      m_ar_addr  <= (nxt == POLL_AR) ? BASE_ADDR + ADDR_BITS'(8) :
                    (nxt == DATA_AR) ? BASE_ADDR : '0;
      m_r_ready  <= (nxt == POLL_R) || (nxt == DATA_R);
      out_valid  <= (nxt == PUSH);
      busy       <= (nxt != IDLE);
      done       <= (nxt == DONE);
      gap_cnt    <= (state == GAP && nxt == GAP) ? gap_cnt + GAP_BITS'(1) : '0;

      if (state == IDLE && start) begin
        word_cnt <= '0;
        err      <= 1'b0;
        ovf      <= 1'b0;
      end
      if (state == POLL_R && r_hs && resp_ok && m_r_data[1])
        ovf <= 1'b1;
      if (state == DATA_R && r_hs && resp_ok)
        out_data <= m_r_data;
      // Free-running runs saturate instead of wrapping.
      if (state == PUSH && out_hs && word_cnt != '1)
        word_cnt <= cnt_inc;
      if (nxt == ERR)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sipo_drain_ctrl.sv
// Bench for sipo_drain_ctrl: FIFO/AXI slave model, word scoreboard and protocol monitor.
module tb_sipo_drain_ctrl;
  localparam logic [31:0] BASE = 32'h4000_0100;
  localparam int          CNTB = 3;
  localparam int          GAPN = 4;

  logic            clk = 1'b0, rstn = 1'b0, start = 1'b0, stop = 1'b0;
  logic [CNTB-1:0] cfg_words = '0;
  logic            m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [31:0]     m_ar_addr, m_r_data, out_data;
  logic [2:0]      m_ar_prot;
  logic [1:0]      m_r_resp;
  logic            out_valid, out_ready, busy, done, err, ovf;
  logic [CNTB-1:0] word_cnt;

  always #5 clk = ~clk;

  sipo_drain_ctrl #(.ADDR_BITS(32), .DATA_BITS(32), .BASE_ADDR(BASE),
                    .CNT_BITS(CNTB), .POLL_GAP(GAPN)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .cfg_words(cfg_words),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_prot(m_ar_prot), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done),
    .err(err), .ovf(ovf), .word_cnt(word_cnt));

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // FIFO model contents, expected words, forced STATUS values
  logic [31:0] fifo[$];
  logic [31:0] exp_q[$];
  logic [1:0]  status_q[$];
  bit  rand_dly = 0, err_on_data = 0, saw_full = 0;
  int  ar_fix = -1, full_pct = 0;
  int  or_mode = 0;
  logic or_hold = 1'b1;

  // AXI4-Lite slave fronting the FIFO model
  bit pend = 0, arh = 0, rh = 0, arw_set = 0;
  logic [31:0] paddr = '0, la = '0, rnd;
  logic [1:0] st;
  int arw = 0, rw = 0;
  initial begin
    m_ar_ready = 0; m_r_valid = 0; m_r_data = '0; m_r_resp = '0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        pend = 0; arh = 0; rh = 0; arw_set = 0; m_ar_ready = 0; m_r_valid = 0;
        continue;
      end
      if (rh) begin m_r_valid = 0; pend = 0; end
      if (arh) begin
        pend = 1; paddr = la; arw_set = 0;
        rw = rand_dly ? int'($urandom_range(0, 3)) : 0;
      end
      m_ar_ready = 0;
      if (m_ar_valid && !pend) begin
        if (!arw_set) begin
          arw = (ar_fix >= 0) ? ar_fix : (rand_dly ? int'($urandom_range(0, 3)) : 0);
          arw_set = 1;
        end
        if (arw == 0) m_ar_ready = 1; else arw--;
      end
      if (pend && !m_r_valid && !rh) begin
        if (rw == 0) begin
          m_r_valid = 1;
          rnd = $urandom;
          if (paddr == BASE + 32'h8) begin
            if (status_q.size() > 0) st = status_q.pop_front();
            else st = {($urandom_range(0, 99) < full_pct), fifo.size() != 0};
            if (st[1]) saw_full = 1;
            m_r_data = {rnd[31:2], st};
            m_r_resp = 2'b00;
          end else if (err_on_data) begin
            err_on_data = 0;
            m_r_resp = 2'b10;
            m_r_data = rnd;
            if (fifo.size() > 0) void'(fifo.pop_front());
          end else begin
            m_r_resp = 2'b00;
            m_r_data = (fifo.size() > 0) ? fifo.pop_front() : 32'hDEAD_BEEF;
          end
        end else rw--;
      end
      arh = m_ar_valid && m_ar_ready;
      la  = m_ar_addr;
      rh  = m_r_valid && m_r_ready;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? 1'($urandom_range(0, 1)) : or_hold;
    end
  end

  // Monitor: scoreboard pops, hold-stability and poll timing
  int cyc = 0, n_out = 0, n_done = 0, n_polls = 0, poll_iv = 0, last_poll = 0;
  int stall = 0, last_stall = 0;
  bit pov = 0, pordy = 0, parv = 0, parr = 0;
  logic [31:0] pod = '0, pad = '0, mon_addr = '0, ew;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin pov = 0; parv = 0; stall = 0; continue; end
      if (pov && !pordy)
        check("push_hold", {out_valid, m_ar_valid, out_data}, {1'b1, 1'b0, pod});
      if (parv && !parr)
        check("ar_hold", {m_ar_valid, m_ar_addr}, {1'b1, pad});
      if (m_ar_valid && !m_ar_ready) stall++;
      if (m_ar_valid && m_ar_ready) begin
        last_stall = stall; stall = 0; mon_addr = m_ar_addr;
        check("ar_addr", (m_ar_addr == BASE) || (m_ar_addr == BASE + 32'h8), 1);
        if (m_ar_addr == BASE + 32'h8) begin
          n_polls++; poll_iv = cyc - last_poll; last_poll = cyc;
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          ew = exp_q.pop_front();
          check("out_data", out_data, ew);
        end
      end
      if (done) n_done++;
      pov = out_valid; pordy = out_ready; pod = out_data;
      parv = m_ar_valid; parr = m_ar_ready; pad = m_ar_addr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick(input int cfg, input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom; fifo.push_back(w); exp_q.push_back(w);
    end
    cfg_words = CNTB'(cfg);
    start = 1; tick(1); start = 0;
  endtask

  // kind: 0 idle, 1 out_valid, 2 m_ar_valid, 3 in DATA_R, 4 all words drained
  task automatic wait_for(input int kind, input string name);
    int t = 0;
    bit hit = 0;
    while (t < 3000 && !hit) begin
      unique case (kind)
        0: hit = !busy;
        1: hit = out_valid;
        2: hit = m_ar_valid;
        3: hit = m_r_ready && mon_addr == BASE;
        default: hit = exp_q.size() == 0 && fifo.size() == 0;
      endcase
      if (!hit) begin tick(1); t++; end
    end
    check(name, hit, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {m_ar_valid, m_ar_prot, m_r_ready, out_valid, busy, done, err, ovf, word_cnt}, '0);
    check({tag, "_addr"}, m_ar_addr, '0);
    check({tag, "_data"}, out_data, '0);
  endtask

  int d0, o0, p0;
  initial begin
    tick(3);
    check_reset_outputs("reset");
    rstn = 1; tick(2);

    // three words, zero-wait slave
    d0 = n_done; o0 = n_out;
    kick(3, 3); wait_for(0, "t1_idle");
    check("t1_words", n_out - o0, 3);
    check("t1_done", n_done - d0, 1);
    check("t1_cnt", word_cnt, 3);
    check("t1_err", err, 0);
    check("t1_left", exp_q.size(), 0);

    // three empty polls, then one word
    status_q = '{2'b00, 2'b00, 2'b00};
    p0 = n_polls; o0 = n_out;
    kick(1, 1); wait_for(0, "t2_idle");
    check("t2_polls", n_polls - p0, 4);
    check("t2_poll_interval", poll_iv, GAPN + 2);
    check("t2_words", n_out - o0, 1);

    // downstream stall while a word is presented
    or_mode = 2; or_hold = 0; o0 = n_out;
    kick(2, 2); wait_for(1, "t3_push");
    tick(10);
    check("t3_valid_held", {out_valid, m_ar_valid}, 2'b10);
    or_mode = 0;
    wait_for(0, "t3_idle");
    check("t3_words", n_out - o0, 2);
    check("t3_cnt", word_cnt, 2);

    // AR ready delayed 5 cycles and SLVERR on DATA
    ar_fix = 5; err_on_data = 1; d0 = n_done; o0 = n_out;
    kick(1, 1); wait_for(0, "t4_idle");
    check("t4_stall", last_stall, 5);
    check("t4_err", err, 1);
    check("t4_no_done", n_done - d0, 0);
    check("t4_no_word", n_out - o0, 0);
    exp_q.delete(); fifo.delete(); ar_fix = -1;

    // STATUS full once: sticky ovf, start clears err
    status_q = '{2'b11};
    kick(1, 1); wait_for(0, "t5_idle");
    check("t5_ovf", ovf, 1);
    check("t5_err_cleared", err, 0);
    kick(1, 1); wait_for(0, "t6_idle");
    check("t6_ovf_cleared", ovf, 0);

    // unlimited run stopped while DATA is in flight
    d0 = n_done; o0 = n_out;
    kick(0, 5); wait_for(3, "t7_data_r");
    stop = 1; wait_for(0, "t7_idle"); stop = 0;
    check("t7_words", n_out - o0, 1);
    check("t7_done", n_done - d0, 1);
    check("t7_cnt", word_cnt, 1);
    check("t7_no_loss", exp_q.size(), fifo.size());
    exp_q.delete(); fifo.delete();

    // unlimited run beyond counter range saturates
    d0 = n_done; o0 = n_out;
    kick(0, 9); wait_for(4, "t8_drained");
    tick(3); stop = 1; wait_for(0, "t8_idle"); stop = 0;
    check("t8_words", n_out - o0, 9);
    check("t8_cnt_sat", word_cnt, 7);
    check("t8_done", n_done - d0, 1);

    // randomized runs
    rand_dly = 1; or_mode = 1; full_pct = 20;
    for (int i = 0; i < 12; i++) begin
      int cfg;
      cfg = $urandom_range(1, 6);
      saw_full = 0; d0 = n_done; o0 = n_out;
      repeat ($urandom_range(0, 2)) status_q.push_back(2'b00);
      kick(cfg, cfg); wait_for(0, "rnd_idle");
      check("rnd_words", n_out - o0, cfg);
      check("rnd_cnt", word_cnt, cfg);
      check("rnd_done", n_done - d0, 1);
      check("rnd_ovf", ovf, saw_full);
      check("rnd_err", err, 0);
      check("rnd_left", exp_q.size(), 0);
    end
    rand_dly = 0; or_mode = 0; full_pct = 0;

    // reset asserted while an AR is held
    ar_fix = 20;
    kick(1, 1); wait_for(2, "t10_ar");
    tick(2); rstn = 0; #1;
    check_reset_outputs("mid_reset");
    tick(2); rstn = 1; ar_fix = -1;
    exp_q.delete(); fifo.delete(); status_q.delete();
    tick(2);
    o0 = n_out;
    kick(2, 2); wait_for(0, "t11_idle");
    check("t11_words", n_out - o0, 2);
    check("t11_cnt", word_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
